instr_seq_ram: RTL
==================

Name: instr_seq_ram

Overview:
- Parametrised instruction store and program counter for one TIS-100 execution node.
- Holds up to 2**ADDR_W instructions, loaded through a write port.
- Presents the instruction at the current PC.
- Advances or branches the PC each enabled cycle from the decoded opcode, ACC and jump offset.
- Adds to the previous generation: configurable depth and widths, program-length tracking with wrap, a stall hold, a program clear, and a PC output.

Parameters:
- ADDR_W, 4, PC/address width; depth = 2**ADDR_W.
- INSTR_W, 21, instruction word width.
- DATA_W, 11, signed ACC/offset width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- clk_en  in  1  global step enable.
- stall  in  1  hold PC; node blocked on port I/O.
- op  in  4  decoded opcode class of the current instruction.
- acc  in  DATA_W  signed ACC value.
- jmp_off  in  DATA_W  signed branch offset, relative to PC.
- write_en  in  1  load strobe.
- write_addr  in  ADDR_W  load address.
- write_data  in  INSTR_W  load data.
- prog_clr  in  1  clear program length.
- out  out  INSTR_W  instruction at PC.
- pc  out  ADDR_W  current PC.

Behaviour:
- Storage: 2**ADDR_W x INSTR_W array, written on clk rising edge when write_en=1, independent of clk_en/stall/reset.
  - Array contents are not cleared by reset or prog_clr.
- prog_len register (ADDR_W+1 bits):
  - On write_en: prog_len <= max(prog_len, write_addr+1).
  - prog_clr=1: prog_len <= 0. prog_clr has priority over a same-cycle write.
  - Not affected by reset, so a program loads before reset is released.
- out = mem[pc] combinational; forced to 0 when prog_len==0.
  - A write to address==pc is visible on out the cycle after the edge.
- Reset (reset==0 at clk edge): pc <= 0. Overrides stepping. Write port stays live during reset.
- Step condition: reset==1 && clk_en==1 && stall==0 && prog_len!=0. Otherwise pc holds.
- Opcode encoding / next PC when stepping:
  - 4'hA JMP: target = pc + jmp_off.
  - 4'hB JEZ: target if acc==0, else seq.
  - 4'hC JNZ: target if acc!=0, else seq.
  - 4'hD JGZ: target if acc>0, else seq.
  - 4'hE JLZ: target if acc<0, else seq.
  - 4'hF JRO: target = pc + acc.
  - all other codes: seq.
- seq = (pc == prog_len-1) ? 0 : pc+1, i.e. wrap at last loaded instruction.
- Branch arithmetic:
  - Sign-extend to ADDR_W+DATA_W+1 bits.
  - Clamp the result to [0, prog_len-1]; no wrap on branches.
- Simultaneous write and step: the step uses the pre-edge prog_len.
- pc >= prog_len after prog_clr and reload: the next step takes seq, which wraps to 0.
- Latency: new pc and out are valid one cycle after the stepping edge.

Optional Feature:
- Macro INSTR_SEQ_RAM_BKPT_EN.
- With the macro, add ports:
  - bkpt_set in 1
  - bkpt_addr in ADDR_W
  - bkpt_resume in 1
  - halted out 1 (reset 0)
- bkpt_set latches bkpt_addr and arms the breakpoint. Reset disarms it.
- On any edge where the new pc equals an armed bkpt_addr, halted <= 1.
- While halted, pc holds as if stall=1.
- bkpt_resume pulse: halted <= 0 and one step is allowed past the breakpoint on that edge. The breakpoint remains armed.
- Without the macro: no extra ports, no halt logic, behaviour as above.

Test Plan:
1. Load 4 NOP words (0x00001..0x00004) at addr 0-3, release reset, clk_en=1, op=0 -> pc 0,1,2,3,0,1; out follows mem[pc].
2. Load 4 words, JMP with jmp_off=+2 at pc=1 -> pc=3. jmp_off=+9 at pc=1 -> pc=3 (clamped). jmp_off=-5 -> pc=0.
3. Conditional branches at pc=0, jmp_off=+2:
   - JEZ acc=0 -> pc=2; JEZ acc=5 -> pc=1.
   - JGZ acc=-1 -> pc=1; JLZ acc=-1 -> pc=2.
   - JRO acc=-3 at pc=2 -> pc=0.
4. stall=1 for 3 cycles at pc=2 -> pc/out hold 3 cycles then resume at 3. clk_en=0 gives identical hold. reset=0 mid-run -> pc=0 next cycle, prog_len unchanged.
5. prog_clr -> out=0 and pc frozen. Reload 2 words -> stepping wraps 0,1,0. Write to addr==pc -> out shows new word next cycle.
6. With INSTR_SEQ_RAM_BKPT_EN: bkpt_addr=2 -> halted=1 with pc=2, pc holds. bkpt_resume -> pc=3, halted=0. Next loop pass halts again at 2.

Source files
------------

// File: rtl/instr_seq_ram_if.sv
// Bus bundle for instr_seq_ram: step controls, branch operands, load port and PC/instruction outputs.
// Breakpoint signals exist only when INSTR_SEQ_RAM_BKPT_EN is defined.
interface instr_seq_ram_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 21,
    parameter int DATA_W  = 11
);
    logic                      clk_en;
    logic                      stall;
    logic [3:0]                op;
    logic signed [DATA_W-1:0]  acc;
    logic signed [DATA_W-1:0]  jmp_off;
    logic                      write_en;
    logic [ADDR_W-1:0]         write_addr;
    logic [INSTR_W-1:0]        write_data;
    logic                      prog_clr;
    logic [INSTR_W-1:0]        out;
    logic [ADDR_W-1:0]         pc;
`ifdef INSTR_SEQ_RAM_BKPT_EN
    logic                      bkpt_set;
    logic [ADDR_W-1:0]         bkpt_addr;
    logic                      bkpt_resume;
    logic                      halted;

    modport master (output clk_en, stall, op, acc, jmp_off, write_en, write_addr, write_data,
                           prog_clr, bkpt_set, bkpt_addr, bkpt_resume,
                    input  out, pc, halted);
    modport slave  (input  clk_en, stall, op, acc, jmp_off, write_en, write_addr, write_data,
                           prog_clr, bkpt_set, bkpt_addr, bkpt_resume,
                    output out, pc, halted);
`else
    modport master (output clk_en, stall, op, acc, jmp_off, write_en, write_addr, write_data,
                           prog_clr,
                    input  out, pc);
    modport slave  (input  clk_en, stall, op, acc, jmp_off, write_en, write_addr, write_data,
                           prog_clr,
                    output out, pc);
`endif
endinterface

// File: rtl/instr_seq_ram.sv
// Instruction store and program counter for one TIS-100 node, with program-length wrap and clamped branches.
// Optional breakpoint/halt logic is enabled by defining INSTR_SEQ_RAM_BKPT_EN.
module instr_seq_ram #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 21,
    parameter int DATA_W  = 11
) (
    input  logic           clk,
    input  logic           reset,
    instr_seq_ram_if.slave bus
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int EXT_W = ADDR_W + DATA_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0]       mem_q [DEPTH];
    logic [LEN_W-1:0]         prog_len_q, prog_len_d;
    logic [LEN_W-1:0]         wr_len;
    logic [LEN_W-1:0]         last_idx;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        seq_pc, target_pc;
    logic signed [DATA_W-1:0] rel;
    logic signed [EXT_W-1:0]  target_raw, last_ext;
    logic                     take, step_base, step;
    logic                     acc_zero, acc_neg, acc_pos;

    always_ff @(posedge clk) begin
        if (bus.write_en) mem_q[bus.write_addr] <= bus.write_data;
    end

    // Program length tracks the highest loaded address; it deliberately ignores reset.
    assign wr_len = {1'b0, bus.write_addr} + LEN_W'(1);

    always_comb begin
        prog_len_d = prog_len_q;
        if (bus.prog_clr) prog_len_d = '0;
        else if (bus.write_en && (wr_len > prog_len_q)) prog_len_d = wr_len;
    end

    always_ff @(posedge clk) prog_len_q <= prog_len_d;

    assign last_idx = prog_len_q - LEN_W'(1);
    assign seq_pc   = ({1'b0, pc_q} >= last_idx) ? '0 : pc_q + ADDR_W'(1);

    assign rel        = (bus.op == 4'hF) ? bus.acc : bus.jmp_off;
    assign target_raw = $signed({{(EXT_W-ADDR_W){1'b0}}, pc_q})
                      + $signed({{(EXT_W-DATA_W){rel[DATA_W-1]}}, rel});
    assign last_ext   = $signed({{(EXT_W-LEN_W){1'b0}}, last_idx});

    always_comb begin
        target_pc = target_raw[ADDR_W-1:0];
        if (target_raw < 0) target_pc = '0;
        else if (target_raw > last_ext) target_pc = last_idx[ADDR_W-1:0];
    end

    assign acc_zero = (bus.acc == '0);
    assign acc_neg  = bus.acc[DATA_W-1];
    assign acc_pos  = !acc_zero && !acc_neg;

    always_comb begin
        take = 1'b0;
        case (bus.op)
            4'hA:    take = 1'b1;
            4'hB:    take = acc_zero;
            4'hC:    take = !acc_zero;
            4'hD:    take = acc_pos;
            4'hE:    take = acc_neg;
            4'hF:    take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    assign step_base = bus.clk_en && !bus.stall && (prog_len_q != '0);

`ifdef INSTR_SEQ_RAM_BKPT_EN
    logic              armed_q;
    logic [ADDR_W-1:0] bkpt_addr_q;
    logic              halted_q, halted_d;

    // A resume pulse lets exactly one step through while halted.
    assign step = step_base && (!halted_q || bus.bkpt_resume);

    always_comb begin
        halted_d = halted_q;
        if (armed_q && (pc_d == bkpt_addr_q)) halted_d = 1'b1;
        else if (bus.bkpt_resume) halted_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_q     <= 1'b0;
            bkpt_addr_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            if (bus.bkpt_set) begin
                armed_q     <= 1'b1;
                bkpt_addr_q <= bus.bkpt_addr;
            end
            halted_q <= halted_d;
        end
    end

    assign bus.halted = halted_q;
`else
    assign step = step_base;
`endif

    always_comb begin
        pc_d = pc_q;
        if (!reset) pc_d = '0;
        else if (step) pc_d = take ? target_pc : seq_pc;
    end

    always_ff @(posedge clk) pc_q <= pc_d;

    assign bus.pc  = pc_q;
    assign bus.out = (prog_len_q == '0) ? '0 : mem_q[pc_q];
endmodule
